// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB-first framing with a valid/ready byte handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD_0   = 9600,
  parameter int BAUD_1   = 19200,
  parameter int BAUD_2   = 57600,
  parameter int BAUD_3   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] brate_selection,
  input  logic [7:0] byte_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_output,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV_0   = CLK_FREQ / BAUD_0;
  localparam int DIV_1   = CLK_FREQ / BAUD_1;
  localparam int DIV_2   = CLK_FREQ / BAUD_2;
  localparam int DIV_3   = CLK_FREQ / BAUD_3;
  localparam int MAX_01  = (DIV_0 > DIV_1) ? DIV_0 : DIV_1;
  localparam int MAX_23  = (DIV_2 > DIV_3) ? DIV_2 : DIV_3;
  localparam int MAX_DIV = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_m1_q, div_m1_d;
  logic [CNT_W-1:0]   sel_div_m1;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_output_q, tx_output_d;
  logic               tx_ready_q, tx_ready_d;
  logic               tx_busy_q, tx_busy_d;
  logic               tx_done_q, tx_done_d;
  logic               bit_end;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // The bit period is stored as DIV-1 so the counter compares directly against it.
  always_comb begin
    sel_div_m1 = CNT_W'(DIV_0 - 1);
    case (brate_selection)
      2'b00:   sel_div_m1 = CNT_W'(DIV_0 - 1);
      2'b01:   sel_div_m1 = CNT_W'(DIV_1 - 1);
      2'b10:   sel_div_m1 = CNT_W'(DIV_2 - 1);
      default: sel_div_m1 = CNT_W'(DIV_3 - 1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_m1_d  = div_m1_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    bit_end   = (cnt_q == div_m1_q);
    cnt_d     = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid && tx_ready_q) begin
          shift_d   = byte_data;
          div_m1_d  = sel_div_m1;
          bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^byte_data;
`endif
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they can be registered without lag.
    case (state_d)
      S_START:  tx_output_d = 1'b0;
      S_DATA:   tx_output_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_output_d = parity_d;
`endif
      default:  tx_output_d = 1'b1;
    endcase
    tx_ready_d = (state_d == S_IDLE);
    tx_busy_d  = (state_d != S_IDLE);
    tx_done_d  = (state_d == S_STOP) && (cnt_d == div_m1_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_m1_q    <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      tx_output_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_m1_q    <= div_m1_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
      tx_output_q <= tx_output_d;
      tx_ready_q  <= tx_ready_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_output = tx_output_q;
  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table-driven frames, hand-written corner sequences and random frames,
// all checked against a bit-period model of the serial line.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] brate_selection;
  logic [7:0] byte_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_output;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;
  int divTab [4] = '{120, 60, 20, 10};

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    int         expDiv;
    logic       expParity;
    bit         scramble;
  } vec_t;

  vec_t vecs [8];

  uart_tx #(.CLK_FREQ(1_152_000)) dut (
    .clk             (clk),
    .rst             (rst),
    .brate_selection (brate_selection),
    .byte_data       (byte_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_output       (tx_output),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done)
  );

  always #5 clk = ~clk;

  // Line level during cycle k (1-based, counted from the cycle after acceptance).
  function automatic logic expectedLine(input logic [7:0] d, input int div, input int k);
    int idx;
    idx = (k - 1) / div;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Presents a byte and waits (bounded) for the acceptance edge; returns one cycle after it.
  task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data);
    logic rdy;
    bit ok;
    ok = 1'b0;
    brate_selection = sel;
    byte_data       = data;
    tx_valid        = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      rdy = tx_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) ok = 1'b1;
    end
    checkOutput("accept", ok, 1);
  endtask

  task automatic monitorFrame(input logic [7:0] data, input int div, input bit scramble,
                              input bit holdValid, output logic parSample);
    int len, lineBad, statBad, doneAt, doneCnt;
    len = NBITS * div;
    lineBad = -1; statBad = -1; doneAt = -1; doneCnt = 0;
    parSample = 1'bx;
    if (!holdValid) tx_valid = 1'b0;
    for (int k = 1; k <= len; k++) begin
      if (scramble && k == len / 2) begin
        brate_selection = 2'($urandom_range(3, 0));
        byte_data       = 8'($urandom_range(255, 0));
        tx_valid        = 1'b1;
      end
      if (scramble && k == len / 2 + 5) tx_valid = 1'b0;
      if (tx_output !== expectedLine(data, div, k) && lineBad < 0) lineBad = k;
      if ((tx_busy !== 1'b1 || tx_ready !== 1'b0) && statBad < 0) statBad = k;
      if (tx_done === 1'b1) begin
        doneCnt++;
        doneAt = k;
      end
      if (k == 9 * div + div / 2) parSample = tx_output;
      @(posedge clk); #1;
    end
    checkOutput("line_first_bad_cycle", lineBad, -1);
    checkOutput("status_first_bad_cycle", statBad, -1);
    checkOutput("done_count", doneCnt, 1);
    checkOutput("done_cycle", doneAt, len);
    checkOutput("idle_line", tx_output, 1);
    checkOutput("idle_ready", tx_ready, 1);
    checkOutput("idle_busy", tx_busy, 0);
  endtask

  task automatic idleCheck(input string name, input int cycles);
    int badAt;
    badAt = -1;
    for (int k = 1; k <= cycles; k++) begin
      if ((tx_output !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) && badAt < 0) badAt = k;
      @(posedge clk); #1;
    end
    checkOutput(name, badAt, -1);
  endtask

  initial begin
    logic parSample;
    logic [1:0] rsel;
    logic [7:0] rdata;

    vecs[0] = '{sel: 2'b11, data: 8'hA5, expDiv: 10,  expParity: 1'b0, scramble: 1'b0};
    vecs[1] = '{sel: 2'b00, data: 8'h00, expDiv: 120, expParity: 1'b0, scramble: 1'b1};
    vecs[2] = '{sel: 2'b00, data: 8'h3C, expDiv: 120, expParity: 1'b0, scramble: 1'b0};
    vecs[3] = '{sel: 2'b01, data: 8'h3C, expDiv: 60,  expParity: 1'b0, scramble: 1'b1};
    vecs[4] = '{sel: 2'b10, data: 8'h3C, expDiv: 20,  expParity: 1'b0, scramble: 1'b0};
    vecs[5] = '{sel: 2'b11, data: 8'h3C, expDiv: 10,  expParity: 1'b0, scramble: 1'b1};
    vecs[6] = '{sel: 2'b11, data: 8'h07, expDiv: 10,  expParity: 1'b1, scramble: 1'b0};
    vecs[7] = '{sel: 2'b11, data: 8'h03, expDiv: 10,  expParity: 1'b0, scramble: 1'b0};

    rst = 1'b1;
    tx_valid = 1'b0;
    brate_selection = 2'b00;
    byte_data = 8'h00;
    #12;
    checkOutput("reset_line", tx_output, 1);
    checkOutput("reset_ready", tx_ready, 1);
    checkOutput("reset_busy", tx_busy, 0);
    checkOutput("reset_done", tx_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    idleCheck("idle_after_reset", 20);

    // Reset in the middle of a data bit must return the line high at once.
    applyStimulus(2'b11, 8'hA5);
    tx_valid = 1'b0;
    repeat (35) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checkOutput("midframe_rst_line", tx_output, 1);
    checkOutput("midframe_rst_ready", tx_ready, 1);
    checkOutput("midframe_rst_busy", tx_busy, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    idleCheck("idle_after_midframe_rst", 50);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].data);
      monitorFrame(vecs[i].data, vecs[i].expDiv, vecs[i].scramble, 1'b0, parSample);
`ifdef UART_TX_PARITY_EN
      checkOutput("parity_bit", parSample, vecs[i].expParity);
`endif
      if (vecs[i].scramble) idleCheck("no_send_after_busy_valid", 3 * vecs[i].expDiv);
    end

    $display("[TB] back-to-back frames");
    applyStimulus(2'b11, 8'h55);
    monitorFrame(8'h55, 10, 1'b0, 1'b1, parSample);
    byte_data = 8'hFF;
    @(posedge clk); #1;
    monitorFrame(8'hFF, 10, 1'b0, 1'b0, parSample);

    $display("[TB] random frames");
    for (int i = 0; i < 10; i++) begin
      rsel  = 2'($urandom_range(3, 0));
      rdata = 8'($urandom_range(255, 0));
      applyStimulus(rsel, rdata);
      monitorFrame(rdata, divTab[rsel], 1'b0, 1'b0, parSample);
      if (PAR) checkOutput("rand_parity_bit", parSample, ^rdata);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
